uwire_clk_cfg: RTL

- Sequences configuration of the board clock synthesizer over its MICROWIRE interface: drives CLKUWIRE, DATAUWIRE and LEUWIRE, then PLL_SYNC, then GOE.
- Replaces the constant tie-offs on those top-level pins.
- Software pushes 32-bit register words into an internal FIFO, then issues START.
- The block shifts each word MSB-first, latches it, issues a SYNC pulse after the last word and enables the synthesizer outputs.

---
 rtl/uwire_clk_cfg_if.sv | 10 +
 rtl/uwire_clk_cfg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uwire_clk_cfg_if.sv
// Word-push channel into the MICROWIRE configuration sequencer.
// The master offers WR_DATA/WR_VALID; the slave answers with WR_READY while its FIFO has room.
interface uwire_clk_cfg_if;
    logic [31:0] WR_DATA;
    logic        WR_VALID;
    logic        WR_READY;

    modport master (output WR_DATA, output WR_VALID, input WR_READY);
    modport slave  (input WR_DATA, input WR_VALID, output WR_READY);
endinterface

// File: rtl/uwire_clk_cfg.sv
// Clock-synthesizer MICROWIRE sequencer: shifts buffered 32-bit words MSB-first,
// latches each one, then pulses PLL_SYNC and raises GOE.
module uwire_clk_cfg #(
    parameter int CLK_DIV     = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_CYCLES = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    uwire_clk_cfg_if.slave       wr,
    input  logic                 START,
    input  logic                 ABORT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [7:0]           WORDS_SENT,
    output logic                 CLKUWIRE,
    output logic                 DATAUWIRE,
    output logic                 LEUWIRE,
    output logic                 PLL_SYNC,
    output logic                 GOE
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int SYN_W = $clog2(SYNC_CYCLES + 1);
    localparam int CNT_W = (DIV_W > SYN_W) ? DIV_W : SYN_W;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_CYCLES - 1);
    localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, LOAD, SHIFT, HOLD, LATCH, GAP, SYNC, FIN
    } state_t;

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           phase_q, phase_d;
    logic [4:0]     bit_q, bit_d;
    logic [31:0]    sh_q, sh_d;
    logic [7:0]     words_d;
    logic           goe_d, clk_d, data_d, le_d, sync_d, done_d;
    logic           pop;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, empty, push;
    logic [31:0]    head;

    assign full        = (count == FIFO_FULL);
    assign empty       = (count == '0);
    assign push        = wr.WR_VALID && !full;
    assign head        = mem[rd_ptr];
    assign wr.WR_READY = !full;
    assign BUSY        = (state_q != IDLE);

    always_ff @(posedge BUS_CLK) begin
        if (push)
            mem[wr_ptr] <= wr.WR_DATA;
    end

    // ABORT flushes the queue, including a word offered in the same cycle.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ABORT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            sh_q       <= '0;
            WORDS_SENT <= '0;
            GOE        <= 1'b0;
            CLKUWIRE   <= 1'b0;
            DATAUWIRE  <= 1'b0;
            LEUWIRE    <= 1'b0;
            PLL_SYNC   <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            WORDS_SENT <= words_d;
            GOE        <= goe_d;
            CLKUWIRE   <= clk_d;
            DATAUWIRE  <= data_d;
            LEUWIRE    <= le_d;
            PLL_SYNC   <= sync_d;
            DONE       <= done_d;
        end
    end

    // The pins are decoded from the next state so they appear registered in step
    // with it; GAP reloads straight into SHIFT to keep words back-to-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        words_d = WORDS_SENT;
        goe_d   = GOE;
        pop     = 1'b0;

        if (ABORT) begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
            goe_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (START) begin
                    goe_d   = 1'b0;
                    words_d = '0;
                    cnt_d   = '0;
                    state_d = empty ? SYNC : LOAD;
                end
                LOAD: begin
                    pop     = 1'b1;
                    sh_d    = head;
                    bit_d   = 5'd31;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = SHIFT;
                end
                SHIFT: if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 5'd0) begin
                            state_d = HOLD;
                        end else begin
                            bit_d = bit_q - 5'd1;
                            sh_d  = {sh_q[30:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                HOLD: if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                LATCH: if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                    if (WORDS_SENT != 8'hFF)
                        words_d = WORDS_SENT + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                GAP: if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = head;
                        bit_d   = 5'd31;
                        phase_d = 1'b0;
                        state_d = SHIFT;
                    end else begin
                        state_d = SYNC;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                SYNC: if (cnt_q == SYNC_LAST) begin
                    cnt_d   = '0;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        clk_d  = (state_d == SHIFT) && phase_d;
        data_d = (state_d == SHIFT) && sh_d[31];
        le_d   = (state_d == LATCH);
        sync_d = (state_d == SYNC);
        done_d = (state_d == FIN);
        if (state_d == FIN)
            goe_d = 1'b1;
    end
endmodule
